// File: rtl/calc_sequencer.sv
// rtl/calc_sequencer.sv - key-driven four-digit calculator with a shared multi-cycle mul/div unit
module calc_sequencer #(
    parameter int HOLD_CYCLES = 3
) (
    input  logic        clk,
    input  logic        KEY1,
    input  logic        KEY2,
    input  logic        KEY3,
    input  logic [7:0]  SW,
    output logic [7:0]  a_val,
    output logic [7:0]  b_val,
    output logic [15:0] result,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    // Key path: index 0 = execute (KEY2), index 1 = digit write (KEY3)
    logic [1:0]    keys;
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [CW-1:0] cnt [2];
    logic [1:0]    armed;
    logic [1:0]    key_ev;

    state_t         state;
    state_t         state_nxt;
    logic [3:0][3:0] slot;
    logic [3:0][3:0] slot_nxt;
    logic [7:0]     a_nxt;
    logic [7:0]     b_nxt;
    logic           wr_en;
    logic           ex_en;
    logic           div_zero;
    logic           last_step;

    logic [1:0]     op;
    logic [7:0]     opa;
    logic [7:0]     opb;
    logic [15:0]    acc;
    logic [2:0]     iter;
    logic [8:0]     mul_sum;
    logic [8:0]     div_rem;
    logic [9:0]     div_diff;
    logic [15:0]    acc_step;
    logic [15:0]    alu_res;

    assign keys = {KEY3, KEY2};

    // A press must see HOLD_CYCLES consecutive lows; the key is disarmed until seen high again
    always_ff @(posedge clk) begin
        if (!KEY1) begin
            sync1  <= 2'b11;
            sync2  <= 2'b11;
            armed  <= 2'b11;
            key_ev <= 2'b00;
            for (int k = 0; k < 2; k++) begin
                cnt[k] <= '0;
            end
        end else begin
            sync1  <= keys;
            sync2  <= sync1;
            key_ev <= 2'b00;
            for (int k = 0; k < 2; k++) begin
                if (sync2[k]) begin
                    cnt[k]   <= '0;
                    armed[k] <= 1'b1;
                end else if (armed[k]) begin
                    if (cnt[k] == CW'(HOLD_CYCLES - 1)) begin
                        key_ev[k] <= 1'b1;
                        armed[k]  <= 1'b0;
                        cnt[k]    <= '0;
                    end else begin
                        cnt[k] <= cnt[k] + CW'(1);
                    end
                end
            end
        end
    end

    assign wr_en = key_ev[1] && (state != RUN);
    assign ex_en = key_ev[0] && (state != RUN);

    // Digit write is applied ahead of the execute latch so a coincident press sees it
    always_comb begin
        slot_nxt = slot;
        if (wr_en) begin
            slot_nxt[SW[5:4]] = SW[3:0];
        end
    end

    assign a_nxt     = {slot_nxt[0], slot_nxt[1]};
    assign b_nxt     = {slot_nxt[2], slot_nxt[3]};
    assign div_zero  = ex_en && (SW[7:6] == 2'b11) && (b_nxt == 8'h00);
    assign last_step = !op[1] || (iter == 3'd7);

    always_ff @(posedge clk) begin
        if (!KEY1) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE, ERR: begin
                if (ex_en) begin
                    state_nxt = div_zero ? ERR : RUN;
                end
            end
            RUN: begin
                if (last_step) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // acc = {high, low}: mul shifts product right through it, div shifts quotient bits in from the right
    always_comb begin
        mul_sum  = {1'b0, acc[15:8]} + (acc[0] ? {1'b0, opb} : 9'd0);
        div_rem  = {acc[15:8], acc[7]};
        div_diff = {1'b0, div_rem} - {2'b00, opb};
        acc_step = acc;
        if (!op[0]) begin
            acc_step = {mul_sum, acc[7:1]};
        end else if (!div_diff[9]) begin
            acc_step = {div_diff[7:0], acc[6:0], 1'b1};
        end else begin
            acc_step = {div_rem[7:0], acc[6:0], 1'b0};
        end
    end

    always_comb begin
        case (op)
            2'b00:   alu_res = {8'h00, opa} + {8'h00, opb};
            2'b01:   alu_res = {8'h00, opa} - {8'h00, opb};
            default: alu_res = acc_step;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!KEY1) begin
            slot   <= '0;
            op     <= 2'b00;
            opa    <= 8'h00;
            opb    <= 8'h00;
            acc    <= 16'h0000;
            iter   <= 3'd0;
            result <= 16'h0000;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            slot <= slot_nxt;
            done <= 1'b0;
            if (ex_en) begin
                op   <= SW[7:6];
                opa  <= a_nxt;
                opb  <= b_nxt;
                acc  <= {8'h00, a_nxt};
                iter <= 3'd0;
                err  <= div_zero;
            end else if (state == RUN) begin
                acc  <= acc_step;
                iter <= iter + 3'd1;
                if (last_step) begin
                    result <= alu_res;
                    done   <= 1'b1;
                end
            end
        end
    end

    assign a_val = {slot[0], slot[1]};
    assign b_val = {slot[2], slot[3]};
    assign busy  = (state == RUN);

endmodule

// File: tb/tb_calc_sequencer.sv
// tb/tb_calc_sequencer.sv - table-driven and randomized checks of calc_sequencer
module tb_calc_sequencer;

    localparam int HOLD = 3;

    logic        clk = 1'b0;
    logic        KEY1;
    logic        KEY2;
    logic        KEY3;
    logic [7:0]  SW;
    logic [7:0]  a_val;
    logic [7:0]  b_val;
    logic [15:0] result;
    logic        busy;
    logic        done;
    logic        err;

    calc_sequencer #(.HOLD_CYCLES(HOLD)) dut (
        .clk    (clk),
        .KEY1   (KEY1),
        .KEY2   (KEY2),
        .KEY3   (KEY3),
        .SW     (SW),
        .a_val  (a_val),
        .b_val  (b_val),
        .result (result),
        .busy   (busy),
        .done   (done),
        .err    (err)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          busy_cnt;
    int          done_cnt;
    int          interm_bad;
    logic [15:0] model_result;

    typedef struct {
        logic [15:0] digits;
        logic [1:0]  op;
        logic [15:0] exp_res;
        logic        exp_err;
        int          exp_busy;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic write_slot(input logic [1:0] s, input logic [3:0] d);
        SW[5:0] = {s, d};
        KEY3 = 1'b0;
        repeat (HOLD + 5) @(negedge clk);
        KEY3 = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic load(input logic [15:0] dg);
        for (int i = 0; i < 4; i++) begin
            write_slot(2'(i), dg[15 - 4 * i -: 4]);
        end
    endtask

    task automatic exec_window(input logic k2, input logic k3, input int low, input int total);
        logic [15:0] res0;
        res0       = result;
        busy_cnt   = 0;
        done_cnt   = 0;
        interm_bad = 0;
        KEY2 = k2 ? 1'b0 : 1'b1;
        KEY3 = k3 ? 1'b0 : 1'b1;
        for (int i = 0; i < total; i++) begin
            @(negedge clk);
            if (busy) begin
                busy_cnt++;
                if (result !== res0) interm_bad++;
            end
            if (done) done_cnt++;
            if (i + 1 >= low) begin
                KEY2 = 1'b1;
                KEY3 = 1'b1;
            end
        end
    endtask

    task automatic run_checked(input string tag, input logic [15:0] dg, input logic [1:0] op,
                               input logic [15:0] exp_res, input logic exp_err, input int exp_busy);
        load(dg);
        check($sformatf("%s.a_val", tag), a_val, dg[15:8]);
        check($sformatf("%s.b_val", tag), b_val, dg[7:0]);
        SW[7:6] = op;
        exec_window(1'b1, 1'b0, HOLD + 6, 30);
        check($sformatf("%s.result", tag), result, exp_res);
        check($sformatf("%s.err", tag), err, exp_err);
        check($sformatf("%s.busy_cycles", tag), busy_cnt, exp_busy);
        check($sformatf("%s.done_pulses", tag), done_cnt, exp_err ? 0 : 1);
        check($sformatf("%s.no_intermediate", tag), interm_bad, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          bc;
        int          dc;
        logic        seen;
        logic [15:0] dg;
        logic [1:0]  op;
        int          a;
        int          b;
        logic [15:0] exp_res;
        logic        exp_err;
        int          exp_busy;

        vecs[0] = '{digits: 16'h1203, op: 2'b00, exp_res: 16'h0015, exp_err: 1'b0, exp_busy: 1};
        vecs[1] = '{digits: 16'h1234, op: 2'b01, exp_res: 16'hFFDE, exp_err: 1'b0, exp_busy: 1};
        vecs[2] = '{digits: 16'hFFFF, op: 2'b10, exp_res: 16'hFE01, exp_err: 1'b0, exp_busy: 8};
        vecs[3] = '{digits: 16'h6407, op: 2'b11, exp_res: 16'h020E, exp_err: 1'b0, exp_busy: 8};
        vecs[4] = '{digits: 16'h6400, op: 2'b11, exp_res: 16'h020E, exp_err: 1'b1, exp_busy: 0};

        KEY1 = 1'b0;
        KEY2 = 1'b1;
        KEY3 = 1'b1;
        SW   = 8'h00;
        repeat (3) @(negedge clk);
        check("reset.a_val", a_val, 0);
        check("reset.b_val", b_val, 0);
        check("reset.result", result, 0);
        check("reset.busy", busy, 0);
        check("reset.done", done, 0);
        check("reset.err", err, 0);
        KEY1 = 1'b1;
        @(negedge clk);
        model_result = 16'h0000;

        for (int v = 0; v < 5; v++) begin
            run_checked($sformatf("vec%0d", v), vecs[v].digits, vecs[v].op,
                        vecs[v].exp_res, vecs[v].exp_err, vecs[v].exp_busy);
        end
        model_result = 16'h020E;

        // KEY2 and KEY3 pressed again while a mul is running
        load(16'h1203);
        SW[7:6] = 2'b10;
        KEY2 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (busy) seen = 1'b1;
        end
        check("run_press.busy_start", seen, 1);
        KEY2 = 1'b1;
        bc = seen ? 1 : 0;
        dc = 0;
        @(negedge clk);
        if (busy) bc++;
        if (done) dc++;
        SW = {2'b10, 2'b00, 4'h9};
        KEY2 = 1'b0;
        KEY3 = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy) bc++;
            if (done) dc++;
            if (i == 5) begin
                KEY2 = 1'b1;
                KEY3 = 1'b1;
            end
        end
        check("run_press.busy_cycles", bc, 8);
        check("run_press.done_pulses", dc, 1);
        check("run_press.result", result, 16'h0036);
        check("run_press.slot0_kept", a_val, 8'h12);

        // Long KEY2 hold gives one operation
        SW[7:6] = 2'b00;
        exec_window(1'b1, 1'b0, 50, 60);
        check("hold50.busy_cycles", busy_cnt, 1);
        check("hold50.done_pulses", done_cnt, 1);
        check("hold50.result", result, 16'h0015);

        // Reset on the 4th RUN cycle of a mul
        SW[7:6] = 2'b10;
        KEY2 = 1'b0;
        bc = 0;
        for (int i = 0; i < 40 && bc < 4; i++) begin
            @(negedge clk);
            if (busy) bc++;
        end
        check("abort.reached_run4", bc, 4);
        KEY1 = 1'b0;
        KEY2 = 1'b1;
        @(negedge clk);
        check("abort.a_val", a_val, 0);
        check("abort.b_val", b_val, 0);
        check("abort.result", result, 0);
        check("abort.busy", busy, 0);
        check("abort.done", done, 0);
        check("abort.err", err, 0);
        KEY1 = 1'b1;
        exec_window(1'b0, 1'b0, 0, 20);
        check("abort.no_done", done_cnt, 0);
        check("abort.no_busy", busy_cnt, 0);
        check("abort.result_after", result, 0);
        model_result = 16'h0000;

        // Two-cycle KEY3 glitch
        SW = {2'b00, 2'b00, 4'h9};
        KEY3 = 1'b0;
        repeat (2) @(negedge clk);
        KEY3 = 1'b1;
        repeat (10) @(negedge clk);
        check("glitch.no_write", a_val, 0);

        // Key held low across reset needs a fresh press afterwards
        SW = {2'b00, 2'b01, 4'h5};
        KEY3 = 1'b0;
        repeat (10) @(negedge clk);
        KEY1 = 1'b0;
        repeat (3) @(negedge clk);
        check("held_reset.cleared", a_val, 0);
        KEY1 = 1'b1;
        repeat (10) @(negedge clk);
        check("held_reset.rewrite", a_val, 8'h05);
        KEY3 = 1'b1;
        repeat (3) @(negedge clk);

        // Coincident write and execute
        load(16'h1000);
        SW = {2'b00, 2'b11, 4'h5};
        exec_window(1'b1, 1'b1, HOLD + 6, 30);
        check("coincide.result", result, 16'h0015);
        check("coincide.b_val", b_val, 8'h05);
        check("coincide.done_pulses", done_cnt, 1);
        model_result = 16'h0015;

        // Randomized operations against the arithmetic reference
        for (int r = 0; r < 16; r++) begin
            dg = 16'($urandom);
            op = 2'($urandom_range(0, 3));
            if (op == 2'b11 && $urandom_range(0, 3) == 0) dg[7:0] = 8'h00;
            a = int'(dg[15:8]);
            b = int'(dg[7:0]);
            exp_err  = 1'b0;
            exp_busy = (op < 2) ? 1 : 8;
            case (op)
                2'b00: exp_res = 16'(a + b);
                2'b01: exp_res = 16'(a - b);
                2'b10: exp_res = 16'(a * b);
                default: begin
                    if (b == 0) begin
                        exp_err  = 1'b1;
                        exp_busy = 0;
                        exp_res  = model_result;
                    end else begin
                        exp_res = {8'(a % b), 8'(a / b)};
                    end
                end
            endcase
            run_checked($sformatf("rand%0d", r), dg, op, exp_res, exp_err, exp_busy);
            model_result = exp_res;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/calc_sequencer.md
CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 Parameter HOLD_CYCLES, default 3: a key must be sampled low for this many consecutive clocks before it counts as a press.
REQ-002 clk  in  1  single system clock; all state changes on its rising edge.
REQ-003 KEY1  in  1  reset, synchronous, active-low.
REQ-004 KEY2  in  1  execute key, active-low, asynchronous to clk.
REQ-005 KEY3  in  1  digit-write key, active-low, asynchronous to clk.
REQ-006 SW  in  8  [3:0] digit value, [5:4] slot select, [7:6] operation select.
REQ-007 a_val  out  8  operand A = {slot0, slot1}.
REQ-008 b_val  out  8  operand B = {slot2, slot3}.
REQ-009 result  out  16  last completed result.
REQ-010 busy  out  1  high while an operation runs.
REQ-011 done  out  1  one-cycle pulse when result updates.
REQ-012 err  out  1  divide-by-zero flag.

Function
REQ-013 KEY2 and KEY3 shall each pass through a 2-flop synchronizer before any use.
REQ-014 Press event: a synchronized key low for HOLD_CYCLES consecutive cycles shall raise a 1-cycle event; the key must then be seen high at least 1 cycle before the next event (a held key gives exactly one event).
REQ-015 Lows shorter than HOLD_CYCLES shall produce no event.
REQ-016 FSM states: IDLE, RUN, DONE, ERR; reset state IDLE.
REQ-017 A KEY3 event in IDLE, DONE or ERR shall write SW[3:0] into slot SW[5:4] in the same cycle; a_val/b_val reflect it the next cycle.
REQ-018 KEY3 events in RUN shall be dropped, not queued.
REQ-019 A KEY2 event in IDLE, DONE or ERR (cycle E) shall latch op=SW[7:6] and the operands, clear err, and enter RUN at E+1.
REQ-020 If KEY2 and KEY3 events coincide, the digit write shall take effect first, and the execute shall use the updated operands.
REQ-021 KEY2 events in RUN shall be ignored.
REQ-022 busy shall be high exactly in RUN cycles E+1 .. E+N, where N=1 for add/sub and N=8 for mul/div.
REQ-023 At E+N+1 the state shall be DONE, result shall be updated, and done=1 for that one cycle.
REQ-024 op 00: result = A + B, zero-extended to 16 bits.
REQ-025 op 01: result = A - B, modulo 2^16 (two's complement).
REQ-026 op 10: result = A * B, exact, computed by an 8-iteration shift-add over a private accumulator.
REQ-027 op 11: result = {remainder[7:0], quotient[7:0]}, computed by an 8-iteration restoring divide.
REQ-028 op 11 with B=0: no RUN cycles; at E+1 the state shall be ERR, err=1, done=0, and result unchanged.
REQ-029 result shall hold its previous value throughout RUN; intermediate values shall never appear on result.
REQ-030 The same arithmetic unit shall serve mul and div; only one operation shall be in flight at a time.

Reset
REQ-031 KEY1=0 at a rising edge shall force, at that edge: state IDLE, slots 0, a_val/b_val 0, result 0, busy 0, done 0, err 0, and key-event counters cleared.
REQ-032 Reset in RUN shall abort the operation with no done pulse and no result update.
REQ-033 After KEY1 returns high, a key already held low shall need HOLD_CYCLES fresh low samples before it generates an event.

Verification
REQ-034 Write 1,2,0,3 to slots 0-3, SW[7:6]=00, press KEY2 -> a_val=0x12, b_val=0x03, busy high 1 cycle, result=0x0015, one done pulse.
REQ-035 A=0x12, B=0x34, op 01 -> result=0xFFDE; A=0xFF, B=0xFF, op 10 -> result=0xFE01 with busy high exactly 8 cycles.
REQ-036 A=0x64, B=0x07, op 11 -> result=0x020E; then B=0x00, op 11 -> err=1, result stays 0x020E, no done pulse, busy never high.
REQ-037 During a mul, press KEY3 (slot 0, digit 9) and KEY2 -> slot 0 unchanged, no second operation; a 2-cycle KEY3 glitch in IDLE -> no write.
REQ-038 Hold KEY2 for 50 cycles -> exactly one operation; assert KEY1 at the 4th RUN cycle of a mul -> all outputs 0 next cycle, no done pulse.
REQ-039 KEY2 and KEY3 events in the same cycle (slot 3 := 5, op 00, A=0x10) -> result=0x0015.
